uart_tx_queue: RTL

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_pkg.sv | 14 +
 rtl/byte_fifo.sv | 59 +++++
 rtl/uart_tx_queue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the queued UART transmitter: serializer states and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_t;

    localparam int FRAME_BITS           = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/byte_fifo.sv
// Byte queue with registered count/full/empty; the head byte is presented combinationally on dout.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [7:0]                   din,
    output logic [7:0]                   dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_do_push;
    logic          w_do_pop;
    logic [CW-1:0] w_count_next;

    // A full queue still accepts a byte when the head leaves on the same edge.
    assign w_do_push    = push & (~r_full | pop);
    assign w_do_pop     = pop & ~r_empty;
    assign w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/uart_tx_queue.sv
// 8N1 UART transmitter fed from a byte queue; back-to-back frames when bytes are waiting.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in,
    input  logic [7:0]                   data,
    output logic                         tx,
    output logic                         busy,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int              TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   T_RELOAD = TW'(CLKS_PER_BIT - 1);

    ser_state_t    r_state, w_state_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic [2:0]    r_idx, w_idx_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_tx, w_tx_next;
    logic          r_busy;
    logic          r_overflow;

    logic          w_pop;
    logic          w_push_ok;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [$clog2(DEPTH+1)-1:0] w_count;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in),
        .pop   (w_pop),
        .din   (data),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_push_ok = in & (~w_full | w_pop);

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_timer_next = T_RELOAD;
                    w_shift_next = w_head;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (r_timer == '0) begin
                    w_state_next = S_DATA;
                    w_timer_next = T_RELOAD;
                    w_idx_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            S_DATA: begin
                if (r_timer == '0) begin
                    w_timer_next = T_RELOAD;
                    if (r_idx == 3'd7) begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                        w_tx_next  = r_shift[r_idx + 3'd1];
                    end
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            S_STOP: begin
                if (r_timer == '0) begin
                    // Chain straight into the next start bit so queued bytes leave without a gap.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                        w_timer_next = T_RELOAD;
                        w_shift_next = w_head;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_tx_next    = 1'b1;
                    end
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // Entering IDLE never pops, so the queue after this edge is empty only if nothing was pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_idx      <= w_idx_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_busy     <= (w_state_next != S_IDLE) || !w_empty || w_push_ok;
            r_overflow <= in & w_full & ~w_pop;
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign full     = w_full;
    assign count    = w_count;
    assign overflow = r_overflow;

endmodule
